// File: rtl/number_five_pkg.sv
// number_five_pkg
// Shared constants for the number_five priority encoder: the 2-bit index
// emitted on {X,Y} for each request line.
package number_five_pkg;

  localparam logic [1:0] CODE_D1 = 2'b00;
  localparam logic [1:0] CODE_D2 = 2'b01;
  localparam logic [1:0] CODE_D3 = 2'b10;
  localparam logic [1:0] CODE_D4 = 2'b11;

endpackage : number_five_pkg

// File: rtl/number_five_enc.sv
// number_five_enc
// Purely combinational 4-to-2 priority encoder. D4 has the highest priority.
// With no request asserted the code is forced to 00 and V is low, so the
// output is always a defined value.
// Ports:
//   D1..D4 : request inputs (D1 lowest priority, D4 highest)
//   X, Y   : encoded index of the highest asserted request, X is the MSB
//   V      : at least one request is asserted
module number_five_enc
  import number_five_pkg::*;
(
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic D4,
  output logic X,
  output logic Y,
  output logic V
);

  logic [1:0] code;

  // First matching request wins; the idle case shares CODE_D1 (00) and is
  // distinguished from a real D1 request only by V.
  always_comb begin
    code = CODE_D1;
    if (D4) begin
      code = CODE_D4;
    end else if (D3) begin
      code = CODE_D3;
    end else if (D2) begin
      code = CODE_D2;
    end else begin
      code = CODE_D1;
    end
  end

  assign X = code[1];
  assign Y = code[0];
  assign V = D1 | D2 | D3 | D4;

endmodule : number_five_enc

// File: rtl/number_five.sv
// number_five
// Registered 4-to-2 priority encoder with valid flag. Requests are sampled on
// every rising clock edge and the encoded result appears one cycle later.
// Synchronous active-high reset clears all outputs and overrides capture.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   D1..D4 : request inputs (D1 lowest priority, D4 highest)
//   X, Y   : registered encoded index, X is the MSB
//   V      : registered valid (any request present)
module number_five
  import number_five_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic D4,
  output logic X,
  output logic Y,
  output logic V
);

  logic x_next;
  logic y_next;
  logic v_next;

  number_five_enc u_enc (
    .D1 (D1),
    .D2 (D2),
    .D3 (D3),
    .D4 (D4),
    .X  (x_next),
    .Y  (y_next),
    .V  (v_next)
  );

  // The three output flops are the only state; registering them keeps the
  // outputs glitch-free regardless of when the requests change.
  always_ff @(posedge clk) begin
    if (rst) begin
      X <= 1'b0;
      Y <= 1'b0;
      V <= 1'b0;
    end else begin
      X <= x_next;
      Y <= y_next;
      V <= v_next;
    end
  end

endmodule : number_five

// File: tb/tb_number_five.sv
// tb_number_five
// Self-checking bench for number_five: reset, directed vector table,
// exhaustive sweep with a reset pulse, random stimulus and mid-cycle timing.
module tb_number_five;

  logic clk;
  logic rst;
  logic d1, d2, d3, d4;
  logic x, y, v;

  int assertCount;
  int failCount;

  typedef struct {
    logic [3:0] d;
    logic       rst;
    logic [2:0] expXYV;
    string      name;
  } vector_t;

  vector_t vecs[$];

  number_five dut (
    .clk (clk),
    .rst (rst),
    .D1  (d1),
    .D2  (d2),
    .D3  (d3),
    .D4  (d4),
    .X   (x),
    .Y   (y),
    .V   (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: index of the highest set request bit, valid if any bit set.
  function automatic logic [2:0] refModel(input logic [3:0] d, input logic r);
    logic [2:0] res;
    res = 3'b000;
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        if (d[i]) res = {i[1:0], 1'b1};
      end
    end
    return res;
  endfunction

  task automatic driveInputs(input logic [3:0] d, input logic r);
    {d4, d3, d2, d1} = d;
    rst = r;
  endtask

  // Drive away from the active edge, then sample just after the next edge.
  task automatic applyStimulus(input logic [3:0] d, input logic r);
    @(negedge clk);
    driveInputs(d, r);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expXYV);
    assertCount++;
    if ({x, y, v} !== expXYV) begin
      failCount++;
      $display("[TB] FAIL %s: got XYV=%b, expected XYV=%b", name, {x, y, v}, expXYV);
    end
  endtask

  initial begin
    logic [3:0] rd;
    logic       rr;
    assertCount = 0;
    failCount   = 0;
    driveInputs(4'b1111, 1'b1);

    // Directed table: {D4..D1, rst, expected {X,Y,V}}
    vecs.push_back('{4'b0001, 1'b0, 3'b001, "single_d1"});
    vecs.push_back('{4'b0010, 1'b0, 3'b011, "single_d2"});
    vecs.push_back('{4'b0100, 1'b0, 3'b101, "single_d3"});
    vecs.push_back('{4'b1000, 1'b0, 3'b111, "single_d4"});
    vecs.push_back('{4'b0101, 1'b0, 3'b101, "prio_0101"});
    vecs.push_back('{4'b0011, 1'b0, 3'b011, "prio_0011"});
    vecs.push_back('{4'b1001, 1'b0, 3'b111, "prio_1001"});
    vecs.push_back('{4'b0110, 1'b0, 3'b101, "prio_0110"});
    vecs.push_back('{4'b1111, 1'b0, 3'b111, "prio_1111"});
    vecs.push_back('{4'b0000, 1'b0, 3'b000, "no_request"});
    vecs.push_back('{4'b1010, 1'b1, 3'b000, "reset_over_data"});

    // Reset with all requests high, held for two edges.
    applyStimulus(4'b1111, 1'b1);
    checkOutput("reset_edge1", 3'b000);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("reset_edge2", 3'b000);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("reset_release", 3'b111);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].d, vecs[i].rst);
      checkOutput(vecs[i].name, vecs[i].expXYV);
    end

    // Exhaustive sweep with a reset pulse in the middle.
    for (int i = 0; i < 16; i++) begin
      rd = i[3:0];
      rr = (i == 8);
      applyStimulus(rd, rr);
      checkOutput($sformatf("sweep_%0d_rst%0d", i, rr), refModel(rd, rr));
    end

    // Random stimulus with occasional reset.
    for (int i = 0; i < 60; i++) begin
      rd = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 9) == 0);
      applyStimulus(rd, rr);
      checkOutput($sformatf("random_%0d", i), refModel(rd, rr));
    end

    // Mid-cycle input change must not reach the outputs before the next edge.
    applyStimulus(4'b0001, 1'b0);
    checkOutput("timing_capture", 3'b001);
    #2;
    driveInputs(4'b1000, 1'b0);
    #1;
    checkOutput("timing_hold_early", 3'b001);
    #2;
    checkOutput("timing_hold_late", 3'b001);
    @(posedge clk);
    #1;
    checkOutput("timing_next_edge", 3'b111);
    #3;
    driveInputs(4'b0000, 1'b0);
    #2;
    checkOutput("timing_hold_idle", 3'b111);
    @(posedge clk);
    #1;
    checkOutput("timing_idle_edge", 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_number_five
